cla_multiword_sequencer: RTL and testbench

Multi-precision add/subtract sequencer built around one instance of the team's 16-bit carry-lookahead adder (carry_lookahead_adder_16bit). It accepts a WORDS×16-bit operand pair over a valid/ready handshake and streams it through the single adder one 16-bit word per cycle, least-significant word first. Each word's carry-out is registered and fed back as the next word's carry-in. It returns the full-width result with carry-out and signed-overflow flags over a second valid/ready handshake. It is the shared-adder front end for wide arithmetic in the datapath.

---
 rtl/cla_multiword_sequencer_if.sv | 34 +++
 rtl/cla_multiword_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cla_multiword_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_multiword_sequencer_if.sv
// cla_multiword_sequencer_if
//   Request/response bundle for the multi-word add/subtract sequencer.
//   Request:  in_valid/in_ready handshake carrying in_a, in_b, in_sub, in_cin.
//   Response: out_valid/out_ready handshake carrying out_sum, out_cout, out_ovf.
//   Status:   busy (job in flight or result waiting).
//   master = job source / result sink, slave = sequencer.
interface cla_multiword_sequencer_if #(
   parameter int unsigned WORDS = 4
);
   localparam int unsigned W = 16 * WORDS;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_sub;
   logic          in_cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic          busy;

   modport master (
      output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
endinterface

// File: rtl/cla_multiword_sequencer.sv
// cla_multiword_sequencer
//   Multi-precision add/subtract built around a single 16-bit carry-lookahead
//   adder. Operands are shifted through the adder one 16-bit word per cycle,
//   least-significant word first, with the word carry registered between words.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - slave side of cla_multiword_sequencer_if (job in, result out, busy)
//   Contains carry_lookahead_adder_16bit, the shared 16-bit adder.

// 16-bit adder: four 4-bit groups, group carries resolved by lookahead.
module carry_lookahead_adder_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_cout
);
   logic [15:0] w_p;
   logic [15:0] w_g;
   logic [3:0]  w_gp;
   logic [3:0]  w_gg;
   logic [4:0]  w_gc;
   logic [15:0] w_c;

   assign w_p = i_a ^ i_b;
   assign w_g = i_a & i_b;

   // Group propagate/generate.
   always_comb begin
      w_gp = '0;
      w_gg = '0;
      for (int j = 0; j < 4; j++) begin
         w_gp[j] = &w_p[4*j +: 4];
         w_gg[j] = w_g[4*j+3]
                 | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      end
   end

   // Group carries, fully expanded so no group waits on its neighbour.
   assign w_gc[0] = i_cin;
   assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
   assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

   // Bit carries inside each group, seeded from that group's carry-in.
   always_comb begin
      logic c;
      w_c = '0;
      for (int j = 0; j < 4; j++) begin
         c          = w_gc[j];
         w_c[4*j]   = c;
         for (int i = 0; i < 3; i++) begin
            c              = w_g[4*j+i] | (w_p[4*j+i] & c);
            w_c[4*j+i+1]   = c;
         end
      end
   end

   assign o_sum  = w_p ^ w_c;
   assign o_cout = w_gc[4];
endmodule

module cla_multiword_sequencer #(
   parameter int unsigned WORDS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   cla_multiword_sequencer_if.slave      bus
);
   localparam int unsigned W  = 16 * WORDS;
   localparam int unsigned KW = $clog2(WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_sum;
   logic          r_carry;
   logic          r_cout;
   logic          r_ovf;
   logic [KW-1:0] r_k;

   logic [15:0]   w_sum;
   logic          w_cout;
   logic          w_last;
   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_busy;

   assign w_last = (r_k == KW'(WORDS - 1));

   // Shared adder: always fed from the bottom word of the operand shifters.
   carry_lookahead_adder_16bit u_cla (
      .i_a    (r_a[15:0]),
      .i_b    (r_b[15:0]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
         S_RUN:   if (w_last)        w_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_next = S_IDLE;
         default:                    w_next = S_IDLE;
      endcase
   end

   // Handshake/status outputs decoded from the state register only.
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
         end
         S_DONE:  w_out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: load on accept, shift one word per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.in_a;
                  // Subtract is A + ~B + 1; the +1 rides in on the carry.
                  r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                  r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
                  r_k     <= '0;
               end
            end
            S_RUN: begin
               r_sum   <= {w_sum, r_sum[W-1:16]};
               r_carry <= w_cout;
               r_a     <= {16'h0000, r_a[W-1:16]};
               r_b     <= {16'h0000, r_b[W-1:16]};
               r_k     <= r_k + KW'(1);
               // Top word: capture final carry and signed overflow.
               if (w_last) begin
                  r_cout <= w_cout;
                  r_ovf  <= (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.out_sum   = r_sum;
   assign bus.out_cout  = r_cout;
   assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// tb_cla_multiword_sequencer
//   Scoreboard bench: the stimulus side publishes the expected result for the
//   job it is offering; a negedge monitor queues it when the job is accepted
//   and checks outputs, handshake flags and timing against the queue.
module tb_cla_multiword_sequencer;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 16 * WORDS;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cla_multiword_sequencer_if #(.WORDS(WORDS)) bus ();

   cla_multiword_sequencer #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t q[$];
   exp_t nxt_exp;
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   acc_cnt   = 0;
   int   acc_cyc   = 0;
   int   last_acc  = -1;
   bit   armed     = 1'b0;
   bit   streaming = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out (cycle %0d)", name, cyc);
   endtask

   function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = o;
      return e;
   endfunction

   // Reference: unsigned W+1-bit result for sum/carry, signed W+2-bit result for overflow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
      exp_t                 e;
      logic [W:0]           u;
      logic signed [W+1:0]  sa, sb, sr;
      sa = {{2{a[W-1]}}, a};
      sb = {{2{b[W-1]}}, b};
      if (sub) begin
         u      = {1'b0, a} - {1'b0, b};
         e.cout = ~u[W];
         sr     = sa - sb;
      end else begin
         u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         e.cout = u[W];
         sr     = sa + sb + {{(W+1){1'b0}}, cin};
      end
      e.sum = u[W-1:0];
      e.ovf = (sr[W] != sr[W-1]);
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] v;
      for (int i = 0; i < int'(WORDS); i += 2) v[32*i/2 +: 32] = $urandom;
      return v;
   endfunction

   // Monitor / scoreboard.
   always @(negedge clk) begin
      bit exp_valid;
      cyc++;
      if (armed) begin
         chk("in_ready", W'(bus.in_ready), W'(q.size() == 0));
         chk("busy",     W'(bus.busy),     W'(q.size() != 0));
         exp_valid = (q.size() != 0) && ((cyc - acc_cyc) >= int'(WORDS) + 1);
         chk("out_valid", W'(bus.out_valid), W'(exp_valid));
         if (bus.out_valid && q.size() != 0) begin
            chk("out_sum",  bus.out_sum,      q[0].sum);
            chk("out_cout", W'(bus.out_cout), W'(q[0].cout));
            chk("out_ovf",  W'(bus.out_ovf),  W'(q[0].ovf));
            if (bus.out_ready && !rst) void'(q.pop_front());
         end
      end
      if (rst) begin
         q.delete();
         armed = 1'b1;
      end else if (armed && bus.in_valid && bus.in_ready) begin
         q.push_back(nxt_exp);
         if (streaming && last_acc >= 0)
            chk("accept_interval", W'(cyc - last_acc), W'(WORDS + 2));
         last_acc = cyc;
         acc_cyc  = cyc;
         acc_cnt++;
      end
   end

   task automatic wait_acc();
      int n0 = acc_cnt;
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         if (acc_cnt != n0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("accept");
      #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
      end
      if (q.size() != 0) timeout_fail("drain");
      #1;
   endtask

   task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input exp_t e);
      nxt_exp      = e;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      bus.in_cin   = cin;
      bus.in_valid = 1'b1;
      wait_acc();
      bus.in_valid = 1'b0;
      wait_drain();
   endtask

   initial begin
      logic [W-1:0] a, b;
      logic         s, c;
      bit           seen;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = 1'b0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b1;
      nxt_exp       = '0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_out_valid", W'(bus.out_valid), W'(0));
      chk("rst_out_sum",   bus.out_sum,       W'(0));
      chk("rst_out_cout",  W'(bus.out_cout),  W'(0));
      chk("rst_out_ovf",   W'(bus.out_ovf),   W'(0));
      chk("rst_busy",      W'(bus.busy),      W'(0));
      chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
      @(posedge clk); #1;

      // Carry across every word.
      run_job(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h0, 1'b1, 1'b0));
      // Subtract with borrow; in_cin must be ignored.
      run_job(64'h5, 64'h7, 1'b1, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
      // Signed overflow, add and subtract.
      run_job(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
              mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
      run_job(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
              mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
      // Add with carry-in.
      run_job(64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 1'b1,
              mk(64'h0000_0000_0001_0000, 1'b0, 1'b0));

      // Backpressure: result must hold while inputs churn.
      bus.out_ready = 1'b0;
      a = 64'h1234_5678_9ABC_DEF0;
      b = 64'h0FED_CBA9_8765_4321;
      nxt_exp      = model(a, b, 1'b0, 1'b0);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = 1'b0;
      bus.in_cin   = 1'b0;
      bus.in_valid = 1'b1;
      wait_acc();
      bus.in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) timeout_fail("bp_out_valid");
      repeat (10) begin
         @(posedge clk); #1;
         bus.in_valid = ~bus.in_valid;
         bus.in_a     = rnd_word();
         bus.in_b     = rnd_word();
         bus.in_sub   = 1'($urandom);
         bus.in_cin   = 1'($urandom);
      end
      @(negedge clk);
      chk("bp_in_ready", W'(bus.in_ready), W'(0));
      chk("bp_queue",    W'(q.size()),     W'(1));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_drain();

      // Reset two cycles after acceptance discards the job.
      nxt_exp      = model(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
      bus.in_a     = 64'hAAAA_AAAA_AAAA_AAAA;
      bus.in_b     = 64'h5555_5555_5555_5555;
      bus.in_sub   = 1'b0;
      bus.in_cin   = 1'b1;
      bus.in_valid = 1'b1;
      wait_acc();
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", W'(bus.out_valid), W'(0));
      chk("mid_rst_busy",      W'(bus.busy),      W'(0));
      chk("mid_rst_in_ready",  W'(bus.in_ready),  W'(1));
      @(posedge clk); #1;
      run_job(64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0,
              mk(64'h0001_0000_0000_0000, 1'b0, 1'b0));

      // Streaming at full rate with random operands.
      last_acc      = -1;
      streaming     = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = rnd_word();
         b = rnd_word();
         s = 1'($urandom);
         c = 1'($urandom);
         nxt_exp    = model(a, b, s, c);
         bus.in_a   = a;
         bus.in_b   = b;
         bus.in_sub = s;
         bus.in_cin = c;
         wait_acc();
      end
      bus.in_valid = 1'b0;
      wait_drain();
      streaming = 1'b0;

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
